// File: rtl/mdu_defs_pkg.sv
// Shared definitions for the multiply/divide unit and the decoder that drives it:
// operation codes, HI/LO read selects and default latencies.
package mdu_defs;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MTHI  = 4'd5,
      MDU_MTLO  = 4'd6
   } mdu_op_e;

   localparam logic [1:0] RD_NONE = 2'd0;
   localparam logic [1:0] RD_HI   = 2'd1;
   localparam logic [1:0] RD_LO   = 2'd2;

   localparam int unsigned MDU_DEFAULT_MUL_TIME = 5;
   localparam int unsigned MDU_DEFAULT_DIV_TIME = 10;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

   function automatic logic isMdOp(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_compute.sv
// Combinational datapath of the multiply/divide unit: 64-bit products, quotients and
// remainders, with a write enable that drops for a zero divisor or a non-arithmetic op.
module mdu_compute
   import mdu_defs::*;
(
   input  logic [3:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic        wrEn_o
);

   logic [63:0] prodS;
   logic [63:0] prodU;
   logic        rtZero;
   logic [31:0] absRs;
   logic [31:0] absRt;
   logic [31:0] divS;
   logic [31:0] divU;
   logic [31:0] quoS;
   logic [31:0] remS;
   logic [31:0] quoU;
   logic [31:0] remU;

   // The low 64 bits of a product of sign-extended operands equal the signed product.
   assign prodS = {{32{rs_i[31]}}, rs_i} * {{32{rt_i[31]}}, rt_i};
   assign prodU = {32'd0, rs_i} * {32'd0, rt_i};

   assign rtZero = (rt_i == 32'd0);
   assign absRs  = rs_i[31] ? (~rs_i + 32'd1) : rs_i;
   assign absRt  = rt_i[31] ? (~rt_i + 32'd1) : rt_i;

   // Magnitude division makes 0x80000000 / -1 fall out naturally as 0x80000000 rem 0.
   assign divS = rtZero ? 32'd1 : absRt;
   assign divU = rtZero ? 32'd1 : rt_i;
   assign quoS = absRs / divS;
   assign remS = absRs % divS;
   assign quoU = rs_i / divU;
   assign remU = rs_i % divU;

   always_comb begin
      hi_o   = 32'd0;
      lo_o   = 32'd0;
      wrEn_o = 1'b0;
      case (op_i)
         MDU_MULT: begin
            {hi_o, lo_o} = prodS;
            wrEn_o       = 1'b1;
         end
         MDU_MULTU: begin
            {hi_o, lo_o} = prodU;
            wrEn_o       = 1'b1;
         end
         MDU_DIV: begin
            lo_o   = (rs_i[31] ^ rt_i[31]) ? (~quoS + 32'd1) : quoS;
            hi_o   = rs_i[31] ? (~remS + 32'd1) : remS;
            wrEn_o = !rtZero;
         end
         MDU_DIVU: begin
            lo_o   = quoU;
            hi_o   = remU;
            wrEn_o = !rtZero;
         end
         default: begin
            hi_o   = 32'd0;
            lo_o   = 32'd0;
            wrEn_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: latches the result at Start, holds it pending for a
// programmable latency, then commits to the architectural HI/LO registers.
module mult_div_unit
   import mdu_defs::*;
#(
   parameter int unsigned DEFAULT_MUL_TIME = MDU_DEFAULT_MUL_TIME,
   parameter int unsigned DEFAULT_DIV_TIME = MDU_DEFAULT_DIV_TIME
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDUOP,
   input  logic [3:0]  Time,
   input  logic [1:0]  ReadHILO,
   input  logic        Req,
   input  logic [31:0] RS,
   input  logic [31:0] RT,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] MDUOut
);

   localparam int CNT_W = 8;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      hi_q, hi_d;
   logic [31:0]      lo_q, lo_d;
   logic [31:0]      pHi_q, pHi_d;
   logic [31:0]      pLo_q, pLo_d;
   logic             pWr_q, pWr_d;
   mdu_state_e       state;

   logic [31:0]      resHi;
   logic [31:0]      resLo;
   logic             resWr;
   logic             isMul;
   logic [CNT_W-1:0] startCnt;

   mdu_compute uCompute (
      .op_i   (MDUOP),
      .rs_i   (RS),
      .rt_i   (RT),
      .hi_o   (resHi),
      .lo_o   (resLo),
      .wrEn_o (resWr)
   );

   assign state = (cnt_q != '0) ? ST_RUN : ST_IDLE;
   assign isMul = (MDUOP == MDU_MULT) || (MDUOP == MDU_MULTU);

   always_comb begin
      startCnt = {{(CNT_W-4){1'b0}}, Time};
      if (Time == 4'd0) begin
         startCnt = isMul ? CNT_W'(DEFAULT_MUL_TIME) : CNT_W'(DEFAULT_DIV_TIME);
      end
   end

   // A flushed (Req) instruction never touches state, but an op already running is older
   // and finishes regardless.
   always_comb begin
      cnt_d = cnt_q;
      hi_d  = hi_q;
      lo_d  = lo_q;
      pHi_d = pHi_q;
      pLo_d = pLo_q;
      pWr_d = pWr_q;
      unique case (state)
         ST_IDLE: begin
            if (!Req) begin
               if (Start && isMdOp(MDUOP)) begin
                  pHi_d = resHi;
                  pLo_d = resLo;
                  pWr_d = resWr;
                  cnt_d = startCnt;
               end else if (MDUOP == MDU_MTHI) begin
                  hi_d = RS;
               end else if (MDUOP == MDU_MTLO) begin
                  lo_d = RS;
               end
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q - CNT_W'(1);
            if ((cnt_q == CNT_W'(1)) && pWr_q) begin
               hi_d = pHi_q;
               lo_d = pLo_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         pHi_q <= '0;
         pLo_q <= '0;
         pWr_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         pHi_q <= pHi_d;
         pLo_q <= pLo_d;
         pWr_q <= pWr_d;
      end
   end

   assign Busy = Start | (cnt_q != '0);
   assign HI   = hi_q;
   assign LO   = lo_q;

   always_comb begin
      MDUOut = 32'd0;
      case (ReadHILO)
         RD_HI:   MDUOut = hi_q;
         RD_LO:   MDUOut = lo_q;
         default: MDUOut = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed cases plus randomized ops checked against an
// arithmetic reference model of HI/LO and the expected busy window.
module tb_mult_div_unit;
   import mdu_defs::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [3:0]  MDUOP;
   logic [3:0]  Time;
   logic [1:0]  ReadHILO;
   logic        Req;
   logic [31:0] RS;
   logic [31:0] RT;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic [31:0] MDUOut;

   int          checks   = 0;
   int          failures = 0;
   logic [31:0] mHi = 32'd0;
   logic [31:0] mLo = 32'd0;
   bit          tbRunning = 1'b0;

   always #5 clk = ~clk;

   mult_div_unit dut (
      .clk      (clk),
      .reset    (reset),
      .Start    (Start),
      .MDUOP    (MDUOP),
      .Time     (Time),
      .ReadHILO (ReadHILO),
      .Req      (Req),
      .RS       (RS),
      .RT       (RT),
      .Busy     (Busy),
      .HI       (HI),
      .LO       (LO),
      .MDUOut   (MDUOut)
   );

   // The stall logic upstream must never issue Start while an op is in flight.
   always @(negedge clk) begin
      if (!reset) begin
         assert (!(Start && tbRunning)) else $error("[TB] Start issued while an op is still running");
      end
   end

   function automatic logic [63:0] refResult(input logic [3:0] op, input logic [31:0] a,
                                             input logic [31:0] b, output bit wr);
      longint          sa, sb, sq, sr;
      longint unsigned ua, ub, uq, ur;
      logic [63:0]     res;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      wr  = 1'b1;
      res = 64'd0;
      case (op)
         MDU_MULT:  res = sa * sb;
         MDU_MULTU: res = ua * ub;
         MDU_DIV: begin
            if (b == 32'd0) wr = 1'b0;
            else begin
               sq  = sa / sb;
               sr  = sa % sb;
               res = {sr[31:0], sq[31:0]};
            end
         end
         MDU_DIVU: begin
            if (b == 32'd0) wr = 1'b0;
            else begin
               uq  = ua / ub;
               ur  = ua % ub;
               res = {ur[31:0], uq[31:0]};
            end
         end
         default: wr = 1'b0;
      endcase
      return res;
   endfunction

   task automatic applyStimulus(input logic start, input logic [3:0] op, input logic [3:0] tm,
                                input logic [1:0] rd, input logic req,
                                input logic [31:0] rs, input logic [31:0] rt);
      Start    = start;
      MDUOP    = op;
      Time     = tm;
      ReadHILO = rd;
      Req      = req;
      RS       = rs;
      RT       = rt;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic driveEdge();
      @(posedge clk);
      #1;
   endtask

   // Runs one arithmetic op; poke exercises MTHI (ignored) and Req (no abort) mid-run.
   task automatic runOp(input string tag, input logic [3:0] op, input logic [31:0] rs,
                        input logic [31:0] rt, input int tm, input bit poke);
      logic [63:0] res;
      bit          wr;
      int          n;
      res = refResult(op, rs, rt, wr);
      n   = (tm != 0) ? tm : ((op == MDU_MULT || op == MDU_MULTU) ? 5 : 10);
      driveEdge();
      applyStimulus(1'b1, op, 4'(tm), RD_NONE, 1'b0, rs, rt);
      @(negedge clk);
      checkOutput({tag, " busy_start"}, {31'd0, Busy}, 32'd1);
      for (int i = 0; i < n; i++) begin
         driveEdge();
         tbRunning = 1'b1;
         if (poke) applyStimulus(1'b0, MDU_MTHI, 4'd0, RD_NONE, 1'(i % 2), 32'hDEAD_0000 + i, $urandom);
         else      applyStimulus(1'b0, MDU_NONE, 4'd0, RD_NONE, 1'b0, $urandom, $urandom);
         @(negedge clk);
         checkOutput({tag, " busy_run"}, {31'd0, Busy}, 32'd1);
         checkOutput({tag, " hi_hold"}, HI, mHi);
         checkOutput({tag, " lo_hold"}, LO, mLo);
      end
      driveEdge();
      tbRunning = 1'b0;
      applyStimulus(1'b0, MDU_NONE, 4'd0, RD_NONE, 1'b0, 32'd0, 32'd0);
      if (wr) begin
         mHi = res[63:32];
         mLo = res[31:0];
      end
      @(negedge clk);
      checkOutput({tag, " busy_done"}, {31'd0, Busy}, 32'd0);
      checkOutput({tag, " hi"}, HI, mHi);
      checkOutput({tag, " lo"}, LO, mLo);
   endtask

   task automatic moveTo(input string tag, input logic [3:0] op, input logic [31:0] val,
                         input logic req);
      driveEdge();
      applyStimulus(1'b0, op, 4'd0, RD_NONE, req, val, 32'd0);
      @(negedge clk);
      checkOutput({tag, " busy"}, {31'd0, Busy}, 32'd0);
      driveEdge();
      applyStimulus(1'b0, MDU_NONE, 4'd0, RD_NONE, 1'b0, 32'd0, 32'd0);
      if (!req && op == MDU_MTHI) mHi = val;
      if (!req && op == MDU_MTLO) mLo = val;
      @(negedge clk);
      checkOutput({tag, " hi"}, HI, mHi);
      checkOutput({tag, " lo"}, LO, mLo);
   endtask

   task automatic checkRead(input string tag);
      logic [1:0] sel [3];
      logic [31:0] exp [3];
      sel = '{RD_NONE, RD_HI, RD_LO};
      exp = '{32'd0, mHi, mLo};
      for (int i = 0; i < 3; i++) begin
         driveEdge();
         ReadHILO = sel[i];
         @(negedge clk);
         checkOutput($sformatf("%s mduout_sel%0d", tag, i), MDUOut, exp[i]);
      end
      driveEdge();
      ReadHILO = RD_NONE;
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a, b;
      reset = 1'b1;
      applyStimulus(1'b0, MDU_NONE, 4'd0, RD_HI, 1'b0, 32'd0, 32'd0);
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("reset hi", HI, 32'd0);
      checkOutput("reset lo", LO, 32'd0);
      checkOutput("reset busy", {31'd0, Busy}, 32'd0);
      checkOutput("reset mduout", MDUOut, 32'd0);
      driveEdge();
      reset = 1'b0;
      $display("[TB] reset released");

      runOp("mult_neg", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 5, 1'b0);
      checkOutput("mult_neg hi_const", HI, 32'hFFFF_FFFF);
      checkOutput("mult_neg lo_const", LO, 32'hFFFF_FFFA);
      runOp("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
      checkOutput("multu_max hi_const", HI, 32'hFFFF_FFFE);
      checkOutput("multu_max lo_const", LO, 32'h0000_0001);
      runOp("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 10, 1'b1);
      checkOutput("div_neg lo_const", LO, 32'hFFFF_FFFD);
      checkOutput("div_neg hi_const", HI, 32'hFFFF_FFFF);
      runOp("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 3, 1'b0);
      checkOutput("div_ovf lo_const", LO, 32'h8000_0000);
      checkOutput("div_ovf hi_const", HI, 32'h0000_0000);

      moveTo("mthi", MDU_MTHI, 32'h11, 1'b0);
      moveTo("mtlo", MDU_MTLO, 32'h22, 1'b0);
      runOp("divu_zero", MDU_DIVU, 32'd1234, 32'd0, 7, 1'b0);
      checkOutput("divu_zero hi_const", HI, 32'h11);
      checkOutput("divu_zero lo_const", LO, 32'h22);
      checkRead("read_preset");

      // Start with Req: Busy only in that cycle, nothing committed later.
      driveEdge();
      applyStimulus(1'b1, MDU_MULT, 4'd3, RD_NONE, 1'b1, 32'd5, 32'd7);
      @(negedge clk);
      checkOutput("req_start busy", {31'd0, Busy}, 32'd1);
      driveEdge();
      applyStimulus(1'b0, MDU_NONE, 4'd0, RD_NONE, 1'b0, 32'd0, 32'd0);
      @(negedge clk);
      checkOutput("req_start busy_after", {31'd0, Busy}, 32'd0);
      repeat (5) driveEdge();
      @(negedge clk);
      checkOutput("req_start hi", HI, mHi);
      checkOutput("req_start lo", LO, mLo);
      moveTo("mtlo_req", MDU_MTLO, 32'hBAD0_BAD0, 1'b1);

      for (int k = 0; k < 16; k++) begin
         op = 4'($urandom_range(1, 4));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 3) == 0) b = {28'd0, 4'($urandom)};
         runOp($sformatf("rand%0d_op%0d", k, op), op, a, b, int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
         if (k % 5 == 0) moveTo($sformatf("rand%0d_mthi", k), MDU_MTHI, $urandom, 1'b0);
      end
      checkRead("read_rand");

      // Reset three cycles into a long divide abandons it.
      driveEdge();
      applyStimulus(1'b1, MDU_DIV, 4'd10, RD_NONE, 1'b0, 32'd1000, 32'd7);
      driveEdge();
      tbRunning = 1'b1;
      applyStimulus(1'b0, MDU_NONE, 4'd0, RD_NONE, 1'b0, 32'd0, 32'd0);
      driveEdge();
      reset = 1'b1;
      driveEdge();
      reset = 1'b0;
      tbRunning = 1'b0;
      mHi = 32'd0;
      mLo = 32'd0;
      @(negedge clk);
      checkOutput("rst_mid busy", {31'd0, Busy}, 32'd0);
      checkOutput("rst_mid hi", HI, 32'd0);
      checkOutput("rst_mid lo", LO, 32'd0);
      repeat (12) driveEdge();
      @(negedge clk);
      checkOutput("rst_mid hi_later", HI, 32'd0);
      checkOutput("rst_mid lo_later", LO, 32'd0);
      checkOutput("rst_mid busy_later", {31'd0, Busy}, 32'd0);
      runOp("post_rst_divu", MDU_DIVU, 32'd100, 32'd7, 2, 1'b0);
      checkRead("read_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
